// File: rtl/branch_ctrl.sv
// branch_ctrl: decode-stage branch resolution controller.
// Holds the front of the pipeline while branch operands are not yet final,
// resolves each branch in the same cycle its operands become ready, and keeps
// taken/not-taken statistics plus a sticky operand-wait timeout flag.
module branch_ctrl #(
  parameter int WAIT_MAX = 8,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             D_valid,
  input  logic [3:0]       D_CompOp,
  input  logic             D_rs_ready,
  input  logic             D_rt_ready,
  input  logic [31:0]      D_target,
  input  logic             stall_in,
  input  logic             exc_flush,
  input  logic             comp_out,
  output logic [3:0]       comp_op,
  output logic             stall_D,
  output logic             redirect,
  output logic [31:0]      npc,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] ntaken_cnt,
  output logic             hazard_err
);

  localparam int                WCNT_W     = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [WCNT_W-1:0] WAIT_LIMIT = WCNT_W'(WAIT_MAX);
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_e;

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  taken_q, taken_d;
  logic [CNT_W-1:0]  ntaken_q, ntaken_d;
  logic              hazard_q, hazard_d;

  logic is_br;
  logic need_rt;
  logic ready;
  logic resolve;
  logic park;

  // Branch decode: only opcodes 1..6 are branches; beq/bne also read rt.
  assign is_br   = D_valid && (D_CompOp >= 4'd1) && (D_CompOp <= 4'd6);
  assign need_rt = (D_CompOp == 4'd1) || (D_CompOp == 4'd2);
  assign ready   = D_rs_ready && (D_rt_ready || !need_rt);

  // A ready branch resolves unless a flush or a downstream freeze wins.
  assign resolve = is_br && ready && !stall_in && !exc_flush;
  // A ready branch frozen by stall_in waits in place without resolving.
  assign park    = is_br && ready && stall_in && !exc_flush;

  assign comp_op  = is_br ? D_CompOp : 4'd0;
  assign stall_D  = is_br && !ready && !exc_flush;
  // Redirect is suppressed while reset is held so no PC change escapes reset.
  assign redirect = resolve && comp_out && reset;
  assign npc      = redirect ? D_target : 32'd0;

  assign taken_cnt  = taken_q;
  assign ntaken_cnt = ntaken_q;
  assign hazard_err = hazard_q;

  // Operand-wait FSM: next state and wait counter.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    wait_d  = wait_q;
    if (exc_flush) begin
      state_d = S_IDLE;
      wait_d  = '0;
    end else if (park) begin
      state_d = state_q;
      wait_d  = wait_q;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (is_br && !ready) begin
            state_d = S_WAIT;
            wait_d  = WCNT_W'(1);
          end
        end
        S_WAIT: begin
          if (!is_br || ready) begin
            state_d = S_IDLE;
            wait_d  = '0;
          end else if (wait_q != WAIT_LIMIT) begin
            wait_d = wait_q + WCNT_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          wait_d  = '0;
        end
      endcase
    end
  end

  // Saturating statistics counters and the sticky timeout flag.
  always_comb begin
    taken_d  = taken_q;
    ntaken_d = ntaken_q;
    hazard_d = hazard_q;
    if (resolve && comp_out && (taken_q != CNT_MAX)) begin
      taken_d = taken_q + CNT_W'(1);
    end
    if (resolve && !comp_out && (ntaken_q != CNT_MAX)) begin
      ntaken_d = ntaken_q + CNT_W'(1);
    end
    if ((state_d == S_WAIT) && (wait_d == WAIT_LIMIT)) begin
      hazard_d = 1'b1;
    end
  end

  // State, counter and flag registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: every piece of state is reset, so no stale count survives reset.
      state_q  <= S_IDLE;
      wait_q   <= '0;
      taken_q  <= '0;
      ntaken_q <= '0;
      hazard_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep all registers updating in parallel.
      state_q  <= state_d;
      wait_q   <= wait_d;
      taken_q  <= taken_d;
      ntaken_q <= ntaken_d;
      hazard_q <= hazard_d;
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: directed and randomized checks of branch_ctrl against a
// behavioural model (branch rules, consecutive-stall run length, saturating
// totals).
module tb_branch_ctrl;

  localparam int WAIT_MAX = 8;
  localparam int CNT_W    = 16;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             D_valid;
  logic [3:0]       D_CompOp;
  logic             D_rs_ready;
  logic             D_rt_ready;
  logic [31:0]      D_target;
  logic             stall_in;
  logic             exc_flush;
  logic             comp_out;
  logic [3:0]       comp_op;
  logic             stall_D;
  logic             redirect;
  logic [31:0]      npc;
  logic [CNT_W-1:0] taken_cnt;
  logic [CNT_W-1:0] ntaken_cnt;
  logic             hazard_err;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int m_taken;
  int m_ntaken;
  int m_run;   // consecutive stall cycles of the current branch
  bit m_haz;

  // Expected combinational outputs for the current inputs.
  logic [3:0]  e_comp_op;
  logic        e_stall;
  logic        e_redir;
  logic [31:0] e_npc;

  branch_ctrl #(
    .WAIT_MAX(WAIT_MAX),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .D_valid   (D_valid),
    .D_CompOp  (D_CompOp),
    .D_rs_ready(D_rs_ready),
    .D_rt_ready(D_rt_ready),
    .D_target  (D_target),
    .stall_in  (stall_in),
    .exc_flush (exc_flush),
    .comp_out  (comp_out),
    .comp_op   (comp_op),
    .stall_D   (stall_D),
    .redirect  (redirect),
    .npc       (npc),
    .taken_cnt (taken_cnt),
    .ntaken_cnt(ntaken_cnt),
    .hazard_err(hazard_err)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [3:0] op, input logic rs, input logic rt,
                       input logic [31:0] tgt, input logic st, input logic fl, input logic co);
    D_valid    = v;
    D_CompOp   = op;
    D_rs_ready = rs;
    D_rt_ready = rt;
    D_target   = tgt;
    stall_in   = st;
    exc_flush  = fl;
    comp_out   = co;
    #1;
  endtask

  function automatic bit model_is_branch();
    return D_valid && (D_CompOp inside {[4'd1:4'd6]});
  endfunction

  function automatic bit model_ready();
    bit uses_rt;
    uses_rt = (D_CompOp == 4'd1) || (D_CompOp == 4'd2);
    return D_rs_ready && (D_rt_ready || !uses_rt);
  endfunction

  function automatic void predict();
    bit br, rdy;
    br        = model_is_branch();
    rdy       = model_ready();
    e_comp_op = br ? D_CompOp : 4'd0;
    e_stall   = br && !rdy && !exc_flush;
    e_redir   = br && rdy && !stall_in && !exc_flush && comp_out && reset;
    e_npc     = e_redir ? D_target : 32'd0;
  endfunction

  // Advance the model by one cycle with the present inputs, then clock the DUT.
  task automatic tick();
    bit br, rdy;
    br  = model_is_branch();
    rdy = model_ready();
    if (reset) begin
      if (br && rdy && !stall_in && !exc_flush) begin
        if (comp_out) m_taken  = (m_taken  < CNT_MAX) ? m_taken + 1  : CNT_MAX;
        else          m_ntaken = (m_ntaken < CNT_MAX) ? m_ntaken + 1 : CNT_MAX;
      end
      if (exc_flush) begin
        m_run = 0;
      end else if (br && rdy && stall_in) begin
        m_run = m_run;
      end else if (br && !rdy) begin
        if (m_run < WAIT_MAX) m_run = m_run + 1;
        if (m_run == WAIT_MAX) m_haz = 1'b1;
      end else begin
        m_run = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_taken  = 0;
    m_ntaken = 0;
    m_run    = 0;
    m_haz    = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_clear();
    drive(1'b1, 4'd1, 1'b1, 1'b1, 32'h0000_4444, 1'b0, 1'b0, 1'b1);
    total++;
    if ({taken_cnt, ntaken_cnt, hazard_err} !== {CNT_W'(0), CNT_W'(0), 1'b0}) begin
      bad++;
      $display("FAIL reset_regs got=%h/%h/%b want=0/0/0", taken_cnt, ntaken_cnt, hazard_err);
    end
    total++;
    if ({comp_op, stall_D, redirect, npc} !== {4'd1, 1'b0, 1'b0, 32'd0}) begin
      bad++;
      $display("FAIL reset_ready_outs got=%h/%b/%b/%h want=1/0/0/0", comp_op, stall_D, redirect, npc);
    end
    drive(1'b1, 4'd2, 1'b1, 1'b0, 32'h0000_4444, 1'b0, 1'b0, 1'b1);
    total++;
    if ({comp_op, stall_D, redirect} !== {4'd2, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL reset_stall_outs got=%h/%b/%b want=2/1/0", comp_op, stall_D, redirect);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(1'b0, 4'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_beq_taken();
    do_reset();
    drive(1'b1, 4'd1, 1'b1, 1'b1, 32'h0000_3010, 1'b0, 1'b0, 1'b1);
    total++;
    if ({redirect, npc, stall_D} !== {1'b1, 32'h0000_3010, 1'b0}) begin
      bad++;
      $display("FAIL beq_resolve got=%b/%h/%b want=1/00003010/0", redirect, npc, stall_D);
    end
    tick();
    total++;
    if ({taken_cnt, ntaken_cnt} !== {CNT_W'(1), CNT_W'(0)}) begin
      bad++;
      $display("FAIL beq_count got=%0d/%0d want=1/0", taken_cnt, ntaken_cnt);
    end
  endtask

  task automatic test_bne_wait();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'd2, 1'b1, 1'b0, 32'h0000_5000, 1'b0, 1'b0, 1'b0);
      total++;
      if ({stall_D, redirect} !== 2'b10) begin
        bad++;
        $display("FAIL bne_wait%0d got stall=%b redir=%b want 1/0", i, stall_D, redirect);
      end
      tick();
    end
    drive(1'b1, 4'd2, 1'b1, 1'b1, 32'h0000_5000, 1'b0, 1'b0, 1'b0);
    total++;
    if ({stall_D, redirect, npc} !== {1'b0, 1'b0, 32'd0}) begin
      bad++;
      $display("FAIL bne_resolve got=%b/%b/%h want=0/0/0", stall_D, redirect, npc);
    end
    tick();
    total++;
    if ({taken_cnt, ntaken_cnt, hazard_err} !== {CNT_W'(0), CNT_W'(1), 1'b0}) begin
      bad++;
      $display("FAIL bne_count got=%0d/%0d/%b want=0/1/0", taken_cnt, ntaken_cnt, hazard_err);
    end
  endtask

  task automatic test_bgez_no_rt();
    do_reset();
    drive(1'b1, 4'd3, 1'b1, 1'b0, 32'h0000_0abc, 1'b0, 1'b0, 1'b1);
    total++;
    if ({comp_op, stall_D, redirect, npc} !== {4'd3, 1'b0, 1'b1, 32'h0000_0abc}) begin
      bad++;
      $display("FAIL bgez_resolve got=%h/%b/%b/%h want=3/0/1/00000abc", comp_op, stall_D, redirect, npc);
    end
    tick();
    total++;
    if (taken_cnt !== CNT_W'(1)) begin
      bad++;
      $display("FAIL bgez_count got=%0d want=1", taken_cnt);
    end
  endtask

  task automatic test_hazard();
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 4'd6, 1'b0, 1'b1, 32'h0000_7000, 1'b0, 1'b0, 1'b1);
      tick();
      total++;
      if (hazard_err !== (i >= WAIT_MAX)) begin
        bad++;
        $display("FAIL hazard_wait%0d got=%b want=%b", i, hazard_err, (i >= WAIT_MAX));
      end
    end
    drive(1'b1, 4'd6, 1'b1, 1'b1, 32'h0000_7000, 1'b0, 1'b0, 1'b1);
    total++;
    if ({stall_D, redirect} !== 2'b01) begin
      bad++;
      $display("FAIL hazard_resolve got stall=%b redir=%b want 0/1", stall_D, redirect);
    end
    tick();
    drive(1'b0, 4'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    tick();
    total++;
    if ({hazard_err, taken_cnt} !== {1'b1, CNT_W'(1)}) begin
      bad++;
      $display("FAIL hazard_sticky got=%b/%0d want=1/1", hazard_err, taken_cnt);
    end
  endtask

  task automatic test_flush_stall();
    do_reset();
    drive(1'b1, 4'd1, 1'b1, 1'b1, 32'h0000_9000, 1'b1, 1'b1, 1'b1);
    total++;
    if ({redirect, stall_D, npc} !== {1'b0, 1'b0, 32'd0}) begin
      bad++;
      $display("FAIL flush_stall_outs got=%b/%b/%h want=0/0/0", redirect, stall_D, npc);
    end
    tick();
    drive(1'b1, 4'd6, 1'b0, 1'b1, 32'h0000_9000, 1'b0, 1'b1, 1'b1);
    total++;
    if (stall_D !== 1'b0) begin
      bad++;
      $display("FAIL flush_unready got stall=%b want 0", stall_D);
    end
    tick();
    total++;
    if ({taken_cnt, ntaken_cnt} !== {CNT_W'(0), CNT_W'(0)}) begin
      bad++;
      $display("FAIL flush_count got=%0d/%0d want=0/0", taken_cnt, ntaken_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'd1, 1'b1, 1'b1, 32'h0000_9000, 1'b1, 1'b0, 1'b1);
      total++;
      if ({redirect, stall_D} !== 2'b00) begin
        bad++;
        $display("FAIL stall_in_hold%0d got redir=%b stall=%b want 0/0", i, redirect, stall_D);
      end
      tick();
      total++;
      if (taken_cnt !== CNT_W'(0)) begin
        bad++;
        $display("FAIL stall_in_count%0d got=%0d want=0", i, taken_cnt);
      end
    end
    drive(1'b1, 4'd1, 1'b1, 1'b1, 32'h0000_9000, 1'b0, 1'b0, 1'b1);
    total++;
    if ({redirect, npc} !== {1'b1, 32'h0000_9000}) begin
      bad++;
      $display("FAIL stall_release got=%b/%h want=1/00009000", redirect, npc);
    end
    tick();
    total++;
    if (taken_cnt !== CNT_W'(1)) begin
      bad++;
      $display("FAIL stall_release_count got=%0d want=1", taken_cnt);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      drive(($urandom_range(0, 9) < 8),
            ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 6)),
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 6), $urandom,
            ($urandom_range(0, 9) < 2), ($urandom_range(0, 19) == 0), 1'($urandom));
      predict();
      total++;
      if ({comp_op, stall_D, redirect, npc} !== {e_comp_op, e_stall, e_redir, e_npc}) begin
        bad++;
        $display("FAIL rand_comb%0d got=%h/%b/%b/%h want=%h/%b/%b/%h", i,
                 comp_op, stall_D, redirect, npc, e_comp_op, e_stall, e_redir, e_npc);
      end
      tick();
      total++;
      if ({taken_cnt, ntaken_cnt, hazard_err} !== {CNT_W'(m_taken), CNT_W'(m_ntaken), m_haz}) begin
        bad++;
        $display("FAIL rand_regs%0d got=%0d/%0d/%b want=%0d/%0d/%b", i,
                 taken_cnt, ntaken_cnt, hazard_err, m_taken, m_ntaken, m_haz);
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    drive(1'b1, 4'd1, 1'b1, 1'b1, 32'h0000_1000, 1'b0, 1'b0, 1'b1);
    repeat (CNT_MAX) tick();
    total++;
    if (taken_cnt !== CNT_W'(CNT_MAX)) begin
      bad++;
      $display("FAIL sat_reach got=%h want=%h", taken_cnt, CNT_W'(CNT_MAX));
    end
    tick();
    tick();
    total++;
    if ({taken_cnt, ntaken_cnt} !== {CNT_W'(CNT_MAX), CNT_W'(0)}) begin
      bad++;
      $display("FAIL sat_hold got=%h/%h want=%h/0", taken_cnt, ntaken_cnt, CNT_W'(CNT_MAX));
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    drive(1'b1, 4'd1, 1'b1, 1'b1, 32'h0000_2000, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 4'd2, 1'b1, 1'b1, 32'h0000_2000, 1'b0, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'd6, 1'b0, 1'b1, 32'h0000_2000, 1'b0, 1'b0, 1'b1);
      tick();
    end
    drive(1'b1, 4'd6, 1'b1, 1'b1, 32'h0000_2000, 1'b0, 1'b0, 1'b1);
    #1;
    reset = 1'b0;
    model_clear();
    #1;
    total++;
    if ({taken_cnt, ntaken_cnt, hazard_err} !== {CNT_W'(0), CNT_W'(0), 1'b0}) begin
      bad++;
      $display("FAIL midwait_clear got=%0d/%0d/%b want=0/0/0", taken_cnt, ntaken_cnt, hazard_err);
    end
    total++;
    if ({redirect, comp_op, npc} !== {1'b0, 4'd6, 32'd0}) begin
      bad++;
      $display("FAIL midwait_redirect got=%b/%h/%h want=0/6/0", redirect, comp_op, npc);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 1; i <= WAIT_MAX; i++) begin
      drive(1'b1, 4'd6, 1'b0, 1'b1, 32'h0000_2000, 1'b0, 1'b0, 1'b1);
      tick();
      total++;
      if (hazard_err !== (i >= WAIT_MAX)) begin
        bad++;
        $display("FAIL midwait_restart%0d got=%b want=%b", i, hazard_err, (i >= WAIT_MAX));
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    model_clear();
    drive(1'b0, 4'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_beq_taken();
    test_bne_wait();
    test_bgez_no_rt();
    test_hazard();
    test_flush_stall();
    test_random();
    test_saturation();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 8, giving the operand-wait cycle count at which hazard_err sets.
REQ-002 SHALL have parameter CNT_W, default 16, giving the width of the statistics counters.
REQ-003 SHALL have one clock; reset is asynchronous and active-low; ports named clk and reset.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: reset  input  1  asynchronous active-low reset.
REQ-006 Port: D_valid  input  1  D-stage instruction valid.
REQ-007 Port: D_CompOp  input  4  branch type: 0 none, 1 beq, 2 bne, 3 bgez, 4 bgtz, 5 blez, 6 bltz, 7-15 treated as none.
REQ-008 Port: D_rs_ready  input  1  rs operand final (forwarded or from GRF).
REQ-009 Port: D_rt_ready  input  1  rt operand final.
REQ-010 Port: D_target  input  32  branch target address.
REQ-011 Port: stall_in  input  1  downstream freeze of D stage.
REQ-012 Port: exc_flush  input  1  exception/eret pipeline flush.
REQ-013 Port: comp_out  input  1  comparator result for comp_op.
REQ-014 Port: comp_op  output  4  op driven to comparator.
REQ-015 Port: stall_D  output  1  hold F/D, insert bubble into E.
REQ-016 Port: redirect  output  1  select npc as next PC this cycle.
REQ-017 Port: npc  output  32  redirect address.
REQ-018 Port: taken_cnt  output  CNT_W  taken-branch count.
REQ-019 Port: ntaken_cnt  output  CNT_W  not-taken-branch count.
REQ-020 Port: hazard_err  output  1  sticky operand-wait timeout flag.

Function
REQ-021 br = D_valid and D_CompOp in 1..6; need_rt = D_CompOp in {1,2}; ready = D_rs_ready and (D_rt_ready or not need_rt).
REQ-022 comp_op SHALL equal D_CompOp when br, else 0 (combinational).
REQ-023 FSM states IDLE and WAIT, registered.
REQ-024 IDLE: br and not ready and no exc_flush -> WAIT, wait_cnt := 1.
REQ-025 WAIT: not ready -> stay, wait_cnt increments, saturating at WAIT_MAX.
REQ-026 WAIT: ready -> IDLE, wait_cnt := 0; WAIT with br deasserted -> IDLE, no resolution.
REQ-027 stall_D SHALL be 1 combinationally whenever br and not ready and not exc_flush, in either state.
REQ-028 Resolve cycle = br and ready and not stall_in and not exc_flush; resolution occurs exactly once per branch, in this cycle.
REQ-029 In resolve cycle: redirect = comp_out, npc = D_target; zero added latency (same cycle as operands ready).
REQ-030 redirect SHALL be 0 outside resolve cycles; npc SHALL be 0 whenever redirect is 0.
REQ-031 Delay slot is never killed by this block; taken branch does not flush F.
REQ-032 stall_in high with br ready: no resolution, no counter update, stall_D 0, state unchanged.
REQ-033 Resolve cycle: taken_cnt += 1 if comp_out else ntaken_cnt += 1; each saturates at 2^CNT_W-1.
REQ-034 hazard_err SHALL set on the edge where wait_cnt reaches WAIT_MAX and stay set until reset.
REQ-035 Priority: exc_flush > stall_in > resolve/stall; exc_flush forces next state IDLE, wait_cnt 0, redirect 0, stall_D 0, no counter update.
REQ-036 Environment holds D_CompOp/D_target stable while stall_D is 1; block does not latch them.

Reset
REQ-037 reset low SHALL asynchronously force state IDLE, wait_cnt 0, taken_cnt 0, ntaken_cnt 0, hazard_err 0.
REQ-038 During reset, comp_op, stall_D, redirect and npc SHALL follow their combinational definitions from current inputs, except redirect SHALL be forced 0.
REQ-039 Reset mid-WAIT SHALL abandon the branch; the branch SHALL be re-evaluated from IDLE after release.

Verification
REQ-040 beq, rs=rt ready, comp_out=1, D_target=0x00003010 -> same cycle redirect=1, npc=0x00003010, taken_cnt=1, stall_D=0.
REQ-041 bne, rt_ready=0 for 3 cycles then 1, comp_out=0 -> stall_D=1 for 3 cycles, then redirect=0, ntaken_cnt=1, state IDLE.
REQ-042 bgez with rt_ready=0, rs_ready=1 -> no stall (rt ignored), resolves same cycle.
REQ-043 bltz, rs_ready=0 for 10 cycles (WAIT_MAX=8) -> hazard_err=1 after 8th wait cycle, stays 1 after operands ready and resolution.
REQ-044 Ready beq with exc_flush=1 and stall_in=1 same cycle -> redirect=0, stall_D=0, counters unchanged; stall_in alone -> no count until released, then one count.
REQ-045 2^CNT_W taken resolutions then one more -> taken_cnt holds 0xFFFF (CNT_W=16); reset low mid-WAIT -> all counters 0, state IDLE immediately.
